// File: rtl/mux4_arb_pkg.sv
//==============================================================================
// Module      : mux4_arb_pkg
// Description : Shared constants, FSM state encoding and round-robin search
//               helper for the 4-way arbitrated mux.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set request bit scanning upward from last+1, wrapping modulo NUM_REQ.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   last);
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + SEL_W'(k);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux4.sv
//==============================================================================
// Module      : mux4
// Description : Plain combinational 4:1 single-bit multiplexer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux4 (
    input  logic [1:0] sel,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
//==============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter over four requesters driving a 4:1 data
//               mux. Optional hold timeout enabled by MUX4_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    input  logic               d,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               out
);

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_sel,   w_sel_nxt;
    logic [SEL_W-1:0]   r_last,  w_last_nxt;
    logic               r_busy,  w_busy_nxt;
    logic [NUM_REQ-1:0] r_gnt,   w_gnt_nxt;
    pick_t              w_pick;
    logic               w_take;
    logic               w_mux;

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               w_others;

    assign w_others = |(req & ~(NUM_REQ'(1) << r_sel));
`else
    // Configuration knobs kept for interface compatibility only.
    localparam int c_unused_cfg = MAX_HOLD + CNT_W;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_take      = 1'b0;
        w_pick      = rr_pick(req, r_last);
`ifdef MUX4_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick.found)
                    w_take = 1'b1;
            end
            GRANT: begin
                // Owner bit is clear here, so any hit is a different requester.
                if (!req[r_sel]) begin
                    if (w_pick.found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
`ifdef MUX4_ARB_TIMEOUT_EN
                else if (r_cnt == c_hold_last) begin
                    if (w_others)
                        w_take = 1'b1;
                    else
                        w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_take) begin
            w_state_nxt = GRANT;
            w_busy_nxt  = 1'b1;
            w_sel_nxt   = w_pick.idx;
            w_last_nxt  = w_pick.idx;
`ifdef MUX4_ARB_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
        end

        w_gnt_nxt = '0;
        if (w_busy_nxt)
            w_gnt_nxt[w_sel_nxt] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= SEL_W'(NUM_REQ - 1);
            r_busy  <= 1'b0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_nxt;
    end
`endif

    mux4 u_mux4 (
        .sel (r_sel),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .y   (w_mux)
    );

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign out  = w_mux & r_busy;

endmodule

`default_nettype wire
